// File: rtl/texture_stream_master.sv
// rtl/texture_stream_master.sv - texture upload stream: credit-limited memory reads into a FIFO, drained as an AXI-Stream.
// Reads are only issued while FIFO entries plus in-flight reads fit in FIFO_DEPTH, so responses never overflow.
module texture_stream_master #(
    parameter int STREAM_WIDTH = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int BEATS_WIDTH  = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                    aclk,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [BEATS_WIDTH-1:0]  cmd_beats,
    output logic                    busy,
    output logic                    mem_rd_valid,
    input  logic                    mem_rd_ready,
    output logic [ADDR_WIDTH-1:0]   mem_rd_addr,
    input  logic                    mem_rd_rvalid,
    input  logic [STREAM_WIDTH-1:0] mem_rd_rdata,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    m_axis_tlast,
    output logic [STREAM_WIDTH-1:0] m_axis_tdata
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(STREAM_WIDTH / 8);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t                  r_state;
    logic                    r_cmd_ready;
    logic                    r_busy;
    logic [ADDR_WIDTH-1:0]   r_req_addr;
    logic [BEATS_WIDTH-1:0]  r_req_left;
    logic [BEATS_WIDTH-1:0]  r_out_left;
    logic [CW-1:0]           r_outstanding;
    logic [CW-1:0]           r_count;
    logic [PW-1:0]           r_wr_ptr;
    logic [PW-1:0]           r_rd_ptr;
    logic [STREAM_WIDTH-1:0] r_mem [FIFO_DEPTH];

    logic w_cmd_hs;
    logic w_rd_hs;
    logic w_push;
    logic w_pop;
    logic w_credit;

    assign w_credit = ({1'b0, r_count} + {1'b0, r_outstanding}) < (CW + 1)'(FIFO_DEPTH);
    assign w_cmd_hs = cmd_valid && r_cmd_ready;
    assign w_rd_hs  = mem_rd_valid && mem_rd_ready;
    // Responses arriving while idle belong to a transfer dropped by reset.
    assign w_push   = mem_rd_rvalid && (r_state != IDLE);
    assign w_pop    = m_axis_tvalid && m_axis_tready;

    assign cmd_ready     = r_cmd_ready;
    assign busy          = r_busy;
    assign mem_rd_valid  = (r_state == ISSUE) && (r_req_left != '0) && w_credit;
    assign mem_rd_addr   = r_req_addr;
    assign m_axis_tvalid = (r_count != '0);
    assign m_axis_tlast  = m_axis_tvalid && (r_out_left == BEATS_WIDTH'(1));
    assign m_axis_tdata  = m_axis_tvalid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge aclk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= mem_rd_rdata;
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_cmd_ready   <= 1'b0;
            r_busy        <= 1'b0;
            r_req_addr    <= '0;
            r_req_left    <= '0;
            r_out_left    <= '0;
            r_outstanding <= '0;
            r_count       <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + 1'b1;
                r_out_left <= r_out_left - 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end
            if (w_rd_hs && !w_push) begin
                r_outstanding <= r_outstanding + 1'b1;
            end else if (!w_rd_hs && w_push) begin
                r_outstanding <= r_outstanding - 1'b1;
            end
            if (w_rd_hs) begin
                r_req_addr <= r_req_addr + ADDR_STEP;
                r_req_left <= r_req_left - 1'b1;
            end

            case (r_state)
                IDLE: begin
                    r_cmd_ready <= 1'b1;
                    if (w_cmd_hs && (cmd_beats != '0)) begin
                        r_req_addr  <= cmd_addr;
                        r_req_left  <= cmd_beats;
                        r_out_left  <= cmd_beats;
                        r_busy      <= 1'b1;
                        r_cmd_ready <= 1'b0;
                        r_state     <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (w_rd_hs && (r_req_left == BEATS_WIDTH'(1))) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_pop && m_axis_tlast) begin
                        r_busy      <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
